// File: rtl/axi_frame_reader.sv
// rtl/axi_frame_reader.sv - AXI4 read-master frame fetcher with beat FIFO and pixel unpacker
module axi_frame_reader #(
    parameter int DATA_W          = 32,
    parameter int PIX_W           = 8,
    parameter int MAX_BURST       = 256,
    parameter int FIFO_DEPTH      = 1024,
    parameter int MAX_OUTSTANDING = 2,
    parameter int BYTE_SWAP       = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [31:0]       i_base_addr,
    input  logic [31:0]       i_frame_bytes,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic              m_axi_arid,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int NPIX  = DATA_W / PIX_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ADDR, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              start_d1_q, start_d2_q;
    logic [31:0]       addr_q, beats_rem_q;
    logic [8:0]        len_q, len_calc;
    logic [CW-1:0]     reserved_q, fifo_cnt_q, free_credits;
    logic [2:0]        outst_q;
    logic              err_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] shreg_q;
    logic [IW-1:0]     idx_q;
    logic              unp_valid_q;

    logic        start_pulse, issue_go, done_w, ar_fire, r_accept, last_accept;
    logic        pix_fire, last_fire, fifo_pop;
    logic [12:0] bnd_beats;

    assign start_pulse = start_d1_q & ~start_d2_q & (state_q == S_IDLE);
    assign ar_fire     = (state_q == S_ADDR) & m_axi_arready;
    // Beats with nothing outstanding are leftovers from a frame abandoned by reset.
    assign r_accept    = m_axi_rvalid & (outst_q != 3'd0);
    assign last_accept = r_accept & m_axi_rlast;

    assign bnd_beats    = (13'h1000 - {1'b0, addr_q[11:0]}) >> BSH;
    assign free_credits = CW'(FIFO_DEPTH) - fifo_cnt_q - reserved_q;

    always_comb begin
        len_calc = 9'(MAX_BURST);
        if (beats_rem_q < 32'(MAX_BURST)) len_calc = beats_rem_q[8:0];
        if (bnd_beats < 13'(len_calc))    len_calc = bnd_beats[8:0];
    end

    always_comb begin
        state_d  = state_q;
        issue_go = 1'b0;
        done_w   = 1'b0;
        case (state_q)
            S_IDLE:  if (start_pulse) state_d = S_ISSUE;
            S_ISSUE: begin
                if (beats_rem_q == 32'd0) begin
                    state_d = S_DRAIN;
                end else if (free_credits >= CW'(len_calc) &&
                             outst_q < 3'(MAX_OUTSTANDING)) begin
                    issue_go = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR:  if (m_axi_arready) state_d = S_ISSUE;
            S_DRAIN: begin
                if (outst_q == 3'd0 && fifo_cnt_q == '0 && !unp_valid_q) begin
                    done_w  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            start_d1_q  <= 1'b0;
            start_d2_q  <= 1'b0;
            addr_q      <= '0;
            beats_rem_q <= '0;
            len_q       <= '0;
            reserved_q  <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_d1_q <= i_start;
            start_d2_q <= start_d1_q;
            if (start_pulse) begin
                addr_q      <= i_base_addr;
                beats_rem_q <= i_frame_bytes >> BSH;
            end else if (ar_fire) begin
                addr_q      <= addr_q + (32'(len_q) << BSH);
                beats_rem_q <= beats_rem_q - 32'(len_q);
            end
            if (issue_go) len_q <= len_calc;
            reserved_q <= reserved_q + (ar_fire ? CW'(len_q) : '0) - CW'(r_accept);
            case ({ar_fire, last_accept})
                2'b10:   outst_q <= outst_q + 3'd1;
                2'b01:   outst_q <= outst_q - 3'd1;
                default: outst_q <= outst_q;
            endcase
            if (start_pulse)                           err_q <= 1'b0;
            else if (r_accept && m_axi_rresp != 2'b00) err_q <= 1'b1;
        end
    end

    assign pix_fire  = unp_valid_q & i_pix_ready;
    assign last_fire = pix_fire & (idx_q == IW'(NPIX - 1));
    assign fifo_pop  = (fifo_cnt_q != '0) & (~unp_valid_q | last_fire);

    always_ff @(posedge i_clk) begin
        if (r_accept) mem_q[wr_ptr_q] <= m_axi_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            shreg_q     <= '0;
            idx_q       <= '0;
            unp_valid_q <= 1'b0;
        end else begin
            if (r_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_cnt_q <= fifo_cnt_q + CW'(r_accept) - CW'(fifo_pop);
            // Reloading on the last accepted pixel keeps the stream bubble-free.
            if (fifo_pop) begin
                shreg_q     <= mem_q[rd_ptr_q];
                idx_q       <= '0;
                unp_valid_q <= 1'b1;
            end else if (last_fire) begin
                unp_valid_q <= 1'b0;
            end else if (pix_fire) begin
                shreg_q <= (BYTE_SWAP != 0) ? (shreg_q << PIX_W) : (shreg_q >> PIX_W);
                idx_q   <= idx_q + IW'(1);
            end
        end
    end

    assign o_pix_data    = (BYTE_SWAP != 0) ? shreg_q[DATA_W-1 -: PIX_W] : shreg_q[PIX_W-1:0];
    assign o_pix_valid   = unp_valid_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_w;
    assign o_err         = err_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(len_q - 9'd1);
    assign m_axi_arsize  = 3'(BSH);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_ADDR);
    assign m_axi_arid    = 1'b0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_rready  = 1'b1;

endmodule

// File: doc/axi_frame_reader.md
Name: axi_frame_reader

Overview:
Parametrised AXI4 read-master frame fetcher: streams a frame of i_frame_bytes from DDR at i_base_addr into an internal beat FIFO, then unpacks each beat into pixels on a valid/ready output stream.
Sits between the DDR interconnect and the pixel-processing pipeline (histogram/equalisation).
Adds the following:
- Variable-length final burst.
- 4 KB boundary splitting.
- Credit-based flow control.
- Multiple outstanding bursts.
- Configurable bus and pixel widths.
- Error and done reporting.

Parameters:
DATA_W, 32, AXI data width in bits; 32/64/128.
PIX_W, 8, output pixel width; must divide DATA_W.
MAX_BURST, 256, maximum beats per burst (1..256).
FIFO_DEPTH, 1024, beat FIFO depth; power of 2, >= MAX_BURST.
MAX_OUTSTANDING, 2, maximum AR accepted but not yet completed by rlast (1..4).
BYTE_SWAP, 1, 1 = first pixel taken from the most-significant lane of a beat; 0 = from the least-significant lane.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_start  in  1  level input; rising edge starts a frame
i_base_addr  in  32  frame start byte address, DATA_W/8 aligned
i_frame_bytes  in  32  frame length in bytes; low log2(DATA_W/8) bits ignored
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse at frame completion
o_err  out  1  sticky: any rresp != OKAY this frame
m_axi_araddr  out  32  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant log2(DATA_W/8)
m_axi_arburst  out  2  constant INCR (2'b01)
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address accept
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  data valid
m_axi_rready  out  1  constant 1 (space pre-reserved)
o_pix_data  out  PIX_W  pixel
o_pix_valid  out  1  pixel valid
i_pix_ready  in  1  downstream accept
Unlisted AXI AR sideband signals (id, lock, cache, prot, qos, user) are tied to 0.

Behaviour:
Reset values:
- m_axi_arvalid = 0, o_busy = 0, o_done = 0, o_err = 0, o_pix_valid = 0.
- FIFO flushed; outstanding and credit counters cleared; state IDLE.
- Reset mid-frame abandons the frame; any R beats arriving after reset are accepted and discarded.

Start:
- i_start is registered twice; start pulse = d1 & ~d2, so the frame begins 2 cycles after the rising edge.
- Start edges while o_busy = 1 are ignored.
- On start: latch addr = i_base_addr, beats_rem = i_frame_bytes >> log2(DATA_W/8); clear o_err; set o_busy.

State machine:
- IDLE -> ISSUE on start pulse.
- ISSUE:
  - If beats_rem == 0, go to DRAIN.
  - Otherwise len = min(MAX_BURST, beats_rem, (4096 - addr[11:0]) / (DATA_W/8)).
  - Advance to ADDR only when free_credits >= len and outstanding < MAX_OUTSTANDING.
  - free_credits = FIFO_DEPTH - fifo_count - reserved_beats.
  - While waiting, ISSUE recomputes nothing and arvalid stays 0.
- ADDR:
  - Assert arvalid with araddr = addr, arlen = len-1; hold both stable until arready.
  - On handshake: addr += len*(DATA_W/8); beats_rem -= len; reserved_beats += len; outstanding += 1; go to ISSUE.
- DRAIN:
  - Wait for outstanding == 0 and FIFO empty and pixel unpacker empty.
  - Then pulse o_done for 1 cycle, clear o_busy, go to IDLE.

Counter rules:
- Each R beat (rvalid) is written to the FIFO and decrements reserved_beats.
- rlast decrements outstanding.
- A simultaneous AR handshake and rlast leaves outstanding unchanged.
- Simultaneous reservation and beat arrival nets correctly in the same cycle.
- The FIFO can never overflow; overflow is a verification assertion.

Error handling:
- rresp != 0 on any beat sets o_err; the beat is still pushed.

Pixel unpacker:
- Holds 1 beat and emits DATA_W/PIX_W pixels in lane order per BYTE_SWAP.
- Output follows AXI-stream rules: o_pix_data is stable while o_pix_valid & !i_pix_ready.
- The next beat is popped the same cycle the last pixel of the current beat is accepted, giving no bubble.
- FIFO read-to-valid latency is 1 cycle when the unpacker is empty.

Zero-length frame (i_frame_bytes < DATA_W/8):
- No AR is issued.
- o_done pulses 2 cycles after the start pulse (ISSUE -> DRAIN -> done).

Test Plan:
1. DATA_W=32, base 0x1000_0000, bytes 307200, slave 0-wait, i_pix_ready=1 -> 300 ARs all arlen=255, 307200 pixels in address order, first pixel = rdata[31:24] of beat 0, one o_done, o_err=0.
2. bytes 1000 (250 beats) -> single AR arlen=249; 1000 pixels; done after last pixel accepted.
3. base 0x0000_0F00, bytes 2048, MAX_BURST=256 -> ARs at 0x0F00 len 64 (arlen 63), 0x1000 len 256, 0x1400 len 192; no burst crosses 4 KB.
4. FIFO_DEPTH=512, i_pix_ready=0 for 2000 cycles -> at most 2 ARs issued (512 credits), rready never deasserts, no overflow; releasing ready resumes issue and completes the frame.
5. rresp=2'b10 on beat 17 -> o_err=1 through done, cleared at next start; all beats still delivered.
6. Assert reset mid-frame with 1 burst outstanding, then start a new frame of 1024 bytes -> stale beats dropped, new frame delivers exactly 1024 pixels; i_start pulses while busy are ignored.
